// File: rtl/sub_bytes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sub_bytes_pkg
// Purpose  : Shared types, constants and the AES S-box function used by the
//            shared SubWord engine and its scheduler.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sub_bytes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef enum logic {
    OWN_RD = 1'b0,
    OWN_KE = 1'b1
  } owner_e;

  localparam int RD_WORDS = 4;
  localparam int KE_WORDS = 1;
  localparam int LANES    = 4;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xtime(x);
    end
    return r;
  endfunction

  // S-box computed as multiplicative inverse (b^254, which maps 0 to 0)
  // followed by the affine transform; avoids a 256-entry table.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] r;
    p = b;
    r = 8'h01;
    // Accumulate b^2 * b^4 * ... * b^128 = b^254.
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sub_bytes_sched_sbox_word.sv
`default_nettype none
// ============================================================================
// Module   : sbox_word
// Purpose  : Four registered S-box lanes forming a 32-bit SubWord engine
//            with one cycle of latency. Lane j handles byte [8j+7:8j].
// Ports    : clk     - rising-edge clock
//            i_word  - 32-bit word to substitute
//            o_word  - substituted word, one cycle later
// Revision : 1.0 - initial release
// ============================================================================
module sbox_word
  import sub_bytes_pkg::*;
(
  input  logic        clk,
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  // Lane registers are deliberately not reset: the scheduler only captures
  // their output in states where they hold freshly issued data.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [7:0] lane_q;
    always_ff @(posedge clk) begin
      lane_q <= sbox(i_word[8*j +: 8]);
    end
    assign o_word[8*j +: 8] = lane_q;
  end

endmodule
`default_nettype wire

// File: rtl/sub_bytes_sched.sv
`default_nettype none
// ============================================================================
// Module   : sub_bytes_sched
// Purpose  : Round-robin scheduler sharing one SubWord engine between the
//            round datapath (128-bit SubBytes, four word passes) and key
//            expansion (32-bit SubWord, one pass).
// Ports    : clk, rst_n           - clock, async active-low reset
//            RD_REQ/RD_DATA       - round datapath request and state
//            RD_GNT/RD_DONE       - accept / completion pulses
//            RD_RESULT            - SubBytes(RD_DATA), held to next RD done
//            KE_REQ/KE_WORD       - key expansion request and word
//            KE_GNT/KE_DONE       - accept / completion pulses
//            KE_RESULT            - SubWord(KE_WORD), held to next KE done
// Revision : 1.0 - initial release
// ============================================================================
module sub_bytes_sched
  import sub_bytes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         RD_REQ,
  input  logic [127:0] RD_DATA,
  output logic         RD_GNT,
  output logic         RD_DONE,
  output logic [127:0] RD_RESULT,
  input  logic         KE_REQ,
  input  logic [31:0]  KE_WORD,
  output logic         KE_GNT,
  output logic         KE_DONE,
  output logic [31:0]  KE_RESULT
);

  localparam logic [1:0] C_RD_LAST = 2'(RD_WORDS - 1);
  localparam logic [1:0] C_KE_LAST = 2'(KE_WORDS - 1);

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [1:0]   last_idx_q, last_idx_d;
  owner_e       owner_q, owner_d;
  owner_e       served_q, served_d;
  logic [127:0] job_q, job_d;
  logic [127:0] rd_res_q, rd_res_d;
  logic [31:0]  ke_res_q, ke_res_d;
  logic         rd_gnt_q, rd_gnt_d, ke_gnt_q, ke_gnt_d;
  logic         rd_done_q, rd_done_d, ke_done_q, ke_done_d;

  logic         accept;
  logic         pick_ke;
  logic         capture;
  logic [1:0]   cap_idx;
  logic [31:0]  sbox_in;
  logic [31:0]  sbox_out;

  assign accept  = (state_q == IDLE) && (RD_REQ || KE_REQ);
  // On a tie the requester not served last wins.
  assign pick_ke = KE_REQ && (!RD_REQ || (served_q == OWN_RD));

  // The engine output in a cycle belongs to the word issued one cycle
  // earlier: cnt-1 while still issuing, or the held last index in DRAIN.
  assign capture = ((state_q == ISSUE) && (cnt_q != 2'd0)) || (state_q == DRAIN);
  assign cap_idx = (state_q == DRAIN) ? cnt_q : (cnt_q - 2'd1);

  always_comb begin
    sbox_in = job_q[127:96];
    for (int k = 0; k < RD_WORDS; k++) begin
      if (cnt_q == 2'(k)) sbox_in = job_q[127 - 32*k -: 32];
    end
  end

  sbox_word u_sbox_word (
    .clk    (clk),
    .i_word (sbox_in),
    .o_word (sbox_out)
  );

  // State register (and all other flops).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      last_idx_q <= 2'd0;
      owner_q    <= OWN_RD;
      served_q   <= OWN_RD;
      job_q      <= '0;
      rd_res_q   <= '0;
      ke_res_q   <= '0;
      rd_gnt_q   <= 1'b0;
      ke_gnt_q   <= 1'b0;
      rd_done_q  <= 1'b0;
      ke_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_idx_q <= last_idx_d;
      owner_q    <= owner_d;
      served_q   <= served_d;
      job_q      <= job_d;
      rd_res_q   <= rd_res_d;
      ke_res_q   <= ke_res_d;
      rd_gnt_q   <= rd_gnt_d;
      ke_gnt_q   <= ke_gnt_d;
      rd_done_q  <= rd_done_d;
      ke_done_q  <= ke_done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ISSUE;
          cnt_d   = 2'd0;
        end
      end
      ISSUE: begin
        // Hold cnt on the last word so DRAIN sees the final index.
        if (cnt_q == last_idx_q) state_d = DRAIN;
        else                     cnt_d   = cnt_q + 2'd1;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    last_idx_d = last_idx_q;
    owner_d    = owner_q;
    served_d   = served_q;
    job_d      = job_q;
    rd_res_d   = rd_res_q;
    ke_res_d   = ke_res_q;
    rd_gnt_d   = 1'b0;
    ke_gnt_d   = 1'b0;
    rd_done_d  = 1'b0;
    ke_done_d  = 1'b0;

    if (accept) begin
      owner_d    = pick_ke ? OWN_KE : OWN_RD;
      served_d   = pick_ke ? OWN_KE : OWN_RD;
      // A KE word sits in word slot 0 so both owners share one issue path.
      job_d      = pick_ke ? {KE_WORD, 96'd0} : RD_DATA;
      last_idx_d = pick_ke ? C_KE_LAST : C_RD_LAST;
      rd_gnt_d   = !pick_ke;
      ke_gnt_d   = pick_ke;
    end

    if (capture) begin
      if (owner_q == OWN_KE) begin
        ke_res_d = sbox_out;
      end else begin
        for (int k = 0; k < RD_WORDS; k++) begin
          if (cap_idx == 2'(k)) rd_res_d[127 - 32*k -: 32] = sbox_out;
        end
      end
    end

    if (state_q == DRAIN) begin
      rd_done_d = (owner_q == OWN_RD);
      ke_done_d = (owner_q == OWN_KE);
    end
  end

  assign RD_GNT    = rd_gnt_q;
  assign RD_DONE   = rd_done_q;
  assign RD_RESULT = rd_res_q;
  assign KE_GNT    = ke_gnt_q;
  assign KE_DONE   = ke_done_q;
  assign KE_RESULT = ke_res_q;

endmodule
`default_nettype wire

// File: tb/tb_sub_bytes_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_bytes_sched
// Purpose  : Directed self-checking bench for sub_bytes_sched. Inputs change
//            and outputs are sampled 1 time unit after each rising edge.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sub_bytes_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         RD_REQ;
  logic [127:0] RD_DATA;
  logic         RD_GNT, RD_DONE;
  logic [127:0] RD_RESULT;
  logic         KE_REQ;
  logic [31:0]  KE_WORD;
  logic         KE_GNT, KE_DONE;
  logic [31:0]  KE_RESULT;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] C_FWD     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_FWD_SB  = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] C_REV     = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] C_REV_SB  = 128'h76abd7fe2b670130c56f6bf27b777c63;
  localparam logic [127:0] C_53      = {16{8'h53}};
  localparam logic [127:0] C_ED      = {16{8'hed}};

  always #5 clk = ~clk;

  sub_bytes_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RD_REQ    (RD_REQ),
    .RD_DATA   (RD_DATA),
    .RD_GNT    (RD_GNT),
    .RD_DONE   (RD_DONE),
    .RD_RESULT (RD_RESULT),
    .KE_REQ    (KE_REQ),
    .KE_WORD   (KE_WORD),
    .KE_GNT    (KE_GNT),
    .KE_DONE   (KE_DONE),
    .KE_RESULT (KE_RESULT)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    RD_REQ  = 1'b0;
    KE_REQ  = 1'b0;
    RD_DATA = '0;
    KE_WORD = '0;

    // Reset state
    tick(3);
    chk("rst_rd_gnt",  128'(RD_GNT), 128'd0);
    chk("rst_rd_done", 128'(RD_DONE), 128'd0);
    chk("rst_rd_res",  RD_RESULT, 128'd0);
    chk("rst_ke_gnt",  128'(KE_GNT), 128'd0);
    chk("rst_ke_done", 128'(KE_DONE), 128'd0);
    chk("rst_ke_res",  128'(KE_RESULT), 128'd0);
    rst_n = 1'b1;
    tick(2);

    // KE only, request pulsed for cycle 0
    KE_REQ  = 1'b1;
    KE_WORD = 32'h00010203;
    tick(1);                                   // cycle 1
    KE_REQ = 1'b0;
    chk("ke_gnt_c1",    128'(KE_GNT), 128'd1);
    chk("ke_rd_gnt_c1", 128'(RD_GNT), 128'd0);
    tick(1);                                   // cycle 2
    chk("ke_gnt_c2",  128'(KE_GNT), 128'd0);
    chk("ke_done_c2", 128'(KE_DONE), 128'd0);
    tick(1);                                   // cycle 3
    chk("ke_done_c3",  128'(KE_DONE), 128'd1);
    chk("ke_res_c3",   128'(KE_RESULT), 128'h637c777b);
    chk("ke_rd_res",   RD_RESULT, 128'd0);
    chk("ke_rd_done",  128'(RD_DONE), 128'd0);
    tick(1);                                   // cycle 4
    chk("ke_done_c4", 128'(KE_DONE), 128'd0);

    // RD only, with RD_DATA disturbed after accept
    RD_REQ  = 1'b1;
    RD_DATA = C_FWD;
    tick(1);                                   // cycle 1
    RD_REQ = 1'b0;
    chk("rd_gnt_c1", 128'(RD_GNT), 128'd1);
    RD_DATA = {4{32'hdeadbeef}};
    tick(1);                                   // cycle 2
    chk("rd_gnt_c2", 128'(RD_GNT), 128'd0);
    RD_DATA = {4{32'h12345678}};
    tick(1);
    RD_DATA = '1;
    tick(1);
    RD_DATA = C_53;
    tick(1);                                   // cycle 5
    chk("rd_done_c5", 128'(RD_DONE), 128'd0);
    tick(1);                                   // cycle 6
    chk("rd_done_c6", 128'(RD_DONE), 128'd1);
    chk("rd_res_c6",  RD_RESULT, C_FWD_SB);
    chk("rd_ke_res",  128'(KE_RESULT), 128'h637c777b);
    tick(1);
    chk("rd_done_c7", 128'(RD_DONE), 128'd0);

    // RD request arriving while KE is busy
    KE_REQ  = 1'b1;
    KE_WORD = 32'h53535353;
    tick(1);                                   // cycle 1
    chk("busy_ke_gnt", 128'(KE_GNT), 128'd1);
    KE_REQ  = 1'b0;
    RD_REQ  = 1'b1;
    RD_DATA = C_REV;
    tick(1);                                   // cycle 2
    chk("busy_rd_gnt_c2", 128'(RD_GNT), 128'd0);
    tick(1);                                   // cycle 3
    chk("busy_ke_done", 128'(KE_DONE), 128'd1);
    chk("busy_ke_res",  128'(KE_RESULT), 128'hedededed);
    chk("busy_rd_gnt_c3", 128'(RD_GNT), 128'd0);
    tick(1);                                   // cycle 4
    chk("busy_rd_gnt_c4", 128'(RD_GNT), 128'd1);
    RD_REQ = 1'b0;
    tick(5);                                   // cycle 9
    chk("busy_rd_done", 128'(RD_DONE), 128'd1);
    chk("busy_rd_res",  RD_RESULT, C_REV_SB);
    chk("busy_ke_keep", 128'(KE_RESULT), 128'hedededed);
    tick(1);

    // Reset in cycle 3 of an RD job
    RD_REQ  = 1'b1;
    RD_DATA = C_FWD;
    tick(1);                                   // cycle 1
    RD_REQ = 1'b0;
    tick(2);                                   // cycle 3
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_res", RD_RESULT, 128'd0);
    chk("mid_rst_ke_res", 128'(KE_RESULT), 128'd0);
    chk("mid_rst_rd_done", 128'(RD_DONE), 128'd0);
    tick(1);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk($sformatf("no_done_%0d", i), 128'(RD_DONE), 128'd0);
    end
    RD_REQ  = 1'b1;
    RD_DATA = C_53;
    tick(1);                                   // cycle 1
    RD_REQ = 1'b0;
    chk("fresh_rd_gnt", 128'(RD_GNT), 128'd1);
    tick(5);                                   // cycle 6
    chk("fresh_rd_done", 128'(RD_DONE), 128'd1);
    chk("fresh_rd_res",  RD_RESULT, C_ED);

    // Tie after reset, both requests held
    tick(1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    RD_REQ  = 1'b1;
    KE_REQ  = 1'b1;
    RD_DATA = C_FWD;
    KE_WORD = 32'h00010203;
    tick(1);                                   // cycle 1
    chk("tie_ke_gnt1", 128'(KE_GNT), 128'd1);
    chk("tie_rd_gnt1", 128'(RD_GNT), 128'd0);
    tick(2);                                   // cycle 3
    chk("tie_ke_done1", 128'(KE_DONE), 128'd1);
    chk("tie_ke_res1",  128'(KE_RESULT), 128'h637c777b);
    tick(1);                                   // cycle 4
    chk("tie_rd_gnt4", 128'(RD_GNT), 128'd1);
    chk("tie_ke_gnt4", 128'(KE_GNT), 128'd0);
    tick(5);                                   // cycle 9
    chk("tie_rd_done9", 128'(RD_DONE), 128'd1);
    chk("tie_rd_res9",  RD_RESULT, C_FWD_SB);
    tick(1);                                   // cycle 10
    chk("tie_ke_gnt10", 128'(KE_GNT), 128'd1);
    chk("tie_rd_gnt10", 128'(RD_GNT), 128'd0);
    tick(2);                                   // cycle 12
    chk("tie_ke_done12", 128'(KE_DONE), 128'd1);
    tick(1);                                   // cycle 13
    chk("tie_rd_gnt13", 128'(RD_GNT), 128'd1);
    chk("tie_ke_gnt13", 128'(KE_GNT), 128'd0);
    RD_REQ = 1'b0;
    KE_REQ = 1'b0;
    tick(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sub_bytes_sched.md
# sub_bytes_sched

Shares one 32-bit SubWord engine (four registered SBOX lanes, 1-cycle latency each) between the round datapath and the key-expansion unit. The round datapath submits a full 128-bit state for SubBytes (four word passes). Key expansion submits one 32-bit word for SubWord. The block arbitrates round-robin, sequences the word passes, drains the SBOX pipeline, and returns the assembled result with a one-cycle done pulse. It sits between the round controller / key schedule and the SBOX instances.

## Interface
Parameters: none; all widths are fixed by AES-128.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- RD_REQ  in  1  round datapath request (level)
- RD_DATA  in  128  state to substitute; sampled on the accepting edge
- RD_GNT  out  1  one-cycle pulse: RD job accepted
- RD_DONE  out  1  one-cycle pulse: RD_RESULT valid
- RD_RESULT  out  128  SubBytes(RD_DATA); held until the next RD completion
- KE_REQ  in  1  key-expansion request (level)
- KE_WORD  in  32  word to substitute; sampled on the accepting edge
- KE_GNT  out  1  one-cycle pulse: KE job accepted
- KE_DONE  out  1  one-cycle pulse: KE_RESULT valid
- KE_RESULT  out  32  SubWord(KE_WORD); held until the next KE completion

## Operation
- FSM states:
  - IDLE → ISSUE on the edge where the state is IDLE and any REQ is high. The edge latches the job data, owner, and word count (RD = 4, KE = 1), and clears the issue counter.
  - ISSUE: drive word[cnt] to the SBOX lanes and increment cnt. After the last word → DRAIN.
  - DRAIN: one cycle; the last SBOX output is captured → IDLE.
- Word order:
  - Word k = data[127−32k −: 32], k = 0..3.
  - Lane j substitutes byte [8j+7:8j] of the word.
  - The result word is written to the same position in the result register.
- Capture: the SBOX output for word k is written into the owner's result register at the end of the cycle after word k was issued. The other requester's result register is untouched.
- Arbitration:
  - Single requester → that requester is granted.
  - Both requesting → the requester not served last is granted. The last-served flag updates on accept.
- GNT is registered. It is high in the first ISSUE cycle, for the owner only.
- DONE is registered. It is high in the cycle after DRAIN, for the owner only, with the result already updated.
- Requests are sampled only in IDLE. REQ and data changes in other states are ignored.
- A requester that keeps REQ high after its DONE cycle starts a new job; this is legal back-to-back use.
- No job is aborted or preempted.

## Timing
Cycle 0 is the cycle in which IDLE samples REQ. The accept edge is the end of cycle 0.
- RD job:
  - GNT in cycle 1; issue in cycles 1–4; drain in cycle 5.
  - Captures occur at the ends of cycles 2–5.
  - RD_DONE in cycle 6, when the state is already IDLE.
  - A new request can be accepted at the end of cycle 6, giving a throughput of one RD job per 6 cycles.
- KE job:
  - GNT in cycle 1; issue in cycle 1; drain in cycle 2.
  - KE_DONE in cycle 3; the next job can be accepted at the end of cycle 3.
- Reset (asynchronous, any state):
  - State → IDLE, cnt → 0.
  - All GNT/DONE → 0; RD_RESULT and KE_RESULT → 0.
  - Last-served → RD, so KE wins the first tie.
  - An in-flight job is discarded and no DONE is issued.
  - The SBOX registers are not reset. Their contents are harmless because capture is gated by state.
- Counter: 2 bits. It is compared against count−1 and never wraps while in ISSUE.

## Structure
- Package sub_bytes_pkg:
  - state enum {IDLE, ISSUE, DRAIN};
  - owner enum {OWN_RD, OWN_KE};
  - constants RD_WORDS = 4, KE_WORDS = 1, LANES = 4.
- Sub-module sbox_word:
  - four SBOX instances on one clk;
  - 32-bit in/out;
  - 1-cycle latency.
- Arbitration and the FSM stay in the top level.

## Test plan
- KE only: KE_WORD = 0x00010203, KE_REQ pulsed for cycle 0.
  - Expect KE_GNT in cycle 1.
  - Expect KE_DONE in cycle 3 with KE_RESULT = 0x637c777b.
  - RD outputs unchanged.
- RD only: RD_DATA = 0x000102030405060708090a0b0c0d0e0f.
  - Expect RD_GNT in cycle 1.
  - Expect RD_DONE in cycle 6 with RD_RESULT = 0x637c777bf26b6fc53001672bfed7ab76.
- Tie after reset: RD_REQ and KE_REQ both high and held.
  - KE is granted first (KE_DONE in cycle 3).
  - RD is accepted at the end of cycle 3 (RD_DONE in cycle 9).
  - KE is then granted again.
  - Grants alternate strictly.
- RD request while KE is busy: RD_REQ rises in cycle 1 of a KE job.
  - RD is ignored until IDLE and accepted at the end of cycle 3.
  - KE_RESULT is unaffected by the RD passes.
- Reset mid-job: rst_n low in cycle 3 of an RD job.
  - Outputs are immediately 0 and no RD_DONE is issued.
  - After release, a fresh RD job with 0x53 in every byte yields RD_RESULT = 0xed repeated ×16.
- Data change after accept: RD_DATA is changed in cycles 1–4.
  - The result reflects the value sampled on the accept edge.
